// File: rtl/dma_rd_req_ctrl_if.sv
// Handshake and bus bundle for the DMA read-request controller.
// slave = controller side, master = registers/memory/FIFO side.
interface dma_rd_req_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 32,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_MAX  = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_MAX) + 1;

    logic                  i_go;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [SIZE_WIDTH-1:0] i_size;
    logic [CW-1:0]         i_fifo_space;
    logic                  i_resp_valid;
    logic                  i_mem_rd_ready;
    logic                  o_mem_rd_en;
    logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
    logic [BW-1:0]         o_mem_rd_burst;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_go, i_base_addr, i_size, i_fifo_space,
        input  i_resp_valid, i_mem_rd_ready,
        output o_mem_rd_en, o_mem_rd_addr, o_mem_rd_burst,
        output o_busy, o_done
    );

    modport master (
        output i_go, i_base_addr, i_size, i_fifo_space,
        output i_resp_valid, i_mem_rd_ready,
        input  o_mem_rd_en, o_mem_rd_addr, o_mem_rd_burst,
        input  o_busy, o_done
    );
endinterface

// File: rtl/dma_rd_req_ctrl.sv
// DMA read-request sequencer: splits a transfer into bursts and only
// issues a burst when the downstream FIFO has room for all outstanding words.
module dma_rd_req_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 32,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_MAX  = 4
) (
    input logic               clk,
    input logic               rst,
    dma_rd_req_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_MAX) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SIZE_WIDTH-1:0] r_remaining;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_received;
    logic [CW-1:0]         r_pending;
    logic                  r_resp_valid;

    logic [BW-1:0]         w_burst;
    logic [CW-1:0]         w_inc;
    logic [CW-1:0]         w_dec;
    logic                  w_req;
    logic                  w_drain;
    logic                  w_credit_ok;
    logic                  w_hs;
    logic                  w_rx;
    logic                  w_rx_done;
    logic                  w_last;

    always_comb begin
        w_req   = (r_state == S_REQ);
        w_drain = (r_state == S_DRAIN);
        w_burst = (r_remaining >= SIZE_WIDTH'(BURST_MAX))
                ? BW'(BURST_MAX) : r_remaining[BW-1:0];
        // Extra bit keeps pending + burst from wrapping before the compare
        w_credit_ok = {1'b0, bus.i_fifo_space}
                   >= ({1'b0, r_pending} + (CW+1)'(w_burst));
        w_hs   = w_req && w_credit_ok && bus.i_mem_rd_ready;
        w_last = (r_remaining == SIZE_WIDTH'(w_burst));
        w_rx   = bus.i_resp_valid && (w_req || w_drain)
              && (r_received != r_size);
        w_rx_done = (r_received == r_size)
                 || (w_rx && ((r_received + SIZE_WIDTH'(1)) == r_size));
        w_inc = w_hs ? CW'(w_burst) : '0;
        // Space reflects a write one cycle late, so retire on the delayed strobe
        w_dec = (r_resp_valid && (r_pending != '0)) ? CW'(1) : '0;
    end

    assign bus.o_mem_rd_en    = w_req && w_credit_ok;
    assign bus.o_mem_rd_addr  = r_addr;
    assign bus.o_mem_rd_burst = w_req ? w_burst : '0;
    assign bus.o_busy         = w_req || w_drain;
    assign bus.o_done         = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_size       <= '0;
            r_received   <= '0;
            r_pending    <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= bus.i_resp_valid;
            r_pending    <= r_pending + w_inc - w_dec;
            if (w_rx)
                r_received <= r_received + SIZE_WIDTH'(1);
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_go) begin
                        r_addr      <= bus.i_base_addr;
                        r_remaining <= bus.i_size;
                        r_size      <= bus.i_size;
                        r_received  <= '0;
                        r_state     <= (bus.i_size == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_hs) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(w_burst);
                        r_remaining <= r_remaining - SIZE_WIDTH'(w_burst);
                        if (w_last)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_rx_done)
                        r_state <= S_DONE;
                end
            endcase
        end
    end

    a_pending_bound: assert property (
        @(posedge clk) disable iff (rst) r_pending <= CW'(FIFO_DEPTH)
    );
endmodule

// File: doc/dma_rd_req_ctrl.md
Name: dma_rd_req_ctrl

Overview:
Sequences DMA read requests into the read-data FIFO. It splits a transfer of `size` words into bursts of up to BURST_MAX words. It issues a burst only when the FIFO is guaranteed room for every outstanding word, so the FIFO never overflows and never needs backpressure on responses. It sits between the DMA control registers, the memory read-request port and the FIFO's registered `space` output.

Parameters:
ADDR_WIDTH, 32, width of word address
SIZE_WIDTH, 32, width of transfer size in words
FIFO_DEPTH, 512, depth of the downstream FIFO; sets CW = $clog2(FIFO_DEPTH)+1
BURST_MAX, 4, max words per request; power of 2, <= FIFO_DEPTH; sets BW = $clog2(BURST_MAX)+1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
go  in  1  start pulse; sampled only in IDLE or DONE
base_addr  in  ADDR_WIDTH  start word address, latched on accepted go
size  in  SIZE_WIDTH  transfer length in words, latched on accepted go
fifo_space  in  CW  FIFO free entries; registered, updates the cycle after a write/read
resp_valid  in  1  one response word is written into the FIFO this cycle
mem_rd_en  out  1  read request valid
mem_rd_ready  in  1  memory accepts request this cycle
mem_rd_addr  out  ADDR_WIDTH  request word address
mem_rd_burst  out  BW  request length in words, 1..BURST_MAX
busy  out  1  transfer in progress
done  out  1  transfer complete; held until next accepted go

Behaviour:
- Reset values (async, immediate):
  - state=IDLE; mem_rd_en=0, mem_rd_addr=0, mem_rd_burst=0, busy=0, done=0.
  - remaining=0, pending=0, received=0, resp_valid_r=0.
- States: IDLE, REQ, DRAIN, DONE.
- IDLE/DONE, go=1:
  - Latch addr_r=base_addr, remaining=size, received=0; done<=0.
  - If size==0, next state=DONE, so done=1 the cycle after go. Otherwise next state=REQ.
  - go in REQ/DRAIN is ignored.
- busy=1 in REQ and DRAIN only.
- REQ:
  - burst = min(BURST_MAX, remaining).
  - credit_ok = (fifo_space >= pending + burst), computed at CW+1 bits.
  - mem_rd_en = credit_ok (combinational from registers). mem_rd_addr=addr_r; mem_rd_burst=burst.
  - Handshake = mem_rd_en && mem_rd_ready. On handshake: addr_r += burst (wraps at 2^ADDR_WIDTH); remaining -= burst; pending += burst.
  - If remaining==burst at handshake, next state=DRAIN.
  - Earliest mem_rd_en: the cycle after go.
  - Once asserted, mem_rd_en, addr and burst stay stable until handshake. Credit is non-decreasing while waiting, because FIFO reads only raise space and writes are matched by pending decrements.
- Response accounting:
  - resp_valid_r <= resp_valid.
  - pending decrements on resp_valid_r, not resp_valid, to align with the FIFO's one-cycle space update.
  - Same-cycle handshake and resp_valid_r: pending += burst - 1.
  - received increments on resp_valid (saturating at size). resp_valid in IDLE/DONE or after received==size is ignored.
- DRAIN: mem_rd_en=0. Go to DONE when received==size, counting a resp_valid this cycle. pending may still be 1 at entry to DONE and clears next cycle.
- DONE: done=1, busy=0. go restarts from DONE identically to IDLE.
- Rest mid-transfer: all state abandoned. In-flight responses are the system's responsibility (FIFO is reset alongside).
- Invariant (assertion): pending <= FIFO_DEPTH at all times; pending + FIFO occupancy never exceeds FIFO_DEPTH.

Test Plan:
- FIFO_DEPTH=16, BURST_MAX=4, fifo_space=16, ready=1, 2-cycle response latency; go with base=0x100, size=10 -> requests (0x100,4),(0x104,4),(0x108,2) on consecutive cycles; busy=1; done=1 the cycle after the 10th resp_valid; pending returns to 0.
- go with size=0 -> mem_rd_en never asserted; done=1 one cycle after go; busy stays 0.
- Credit throttle: FIFO model with consumer stalled, initial space=6, size=12 -> first burst 4 issued. Second (4) blocked since 6 < 4+4 and stays blocked after data lands (space=2, pending=0). Release consumer: reading 2 words makes space=4, request issues. No FIFO overflow at any point.
- Backpressure: mem_rd_ready=0 for 5 cycles with mem_rd_en=1 -> addr/burst/en held constant for all 5 cycles; a single handshake on cycle 6; remaining decrements once.
- Async rst mid-REQ after first handshake -> immediately mem_rd_en=0, busy=0, done=0. A following go with base=0x200, size=4 issues (0x200,4) normally.
- go pulses during REQ/DRAIN are ignored (addr/size unchanged). go in DONE with size=3 -> done clears next cycle, request (base,3) issued.
